// File: rtl/select_encode_seq_pkg.sv
// Shared encodings and helpers for the select/encode unit.
package select_encode_seq_pkg;

  // field_id encodings
  localparam logic [1:0] FID_NONE = 2'd0;
  localparam logic [1:0] FID_RA   = 2'd1;
  localparam logic [1:0] FID_RB   = 2'd2;
  localparam logic [1:0] FID_RC   = 2'd3;

  // Sequencer state encoding; each step state has the same code as the field it emits
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RA    = 2'd1;
  localparam logic [1:0] ST_RB    = 2'd2;
  localparam logic [1:0] ST_RC    = 2'd3;

  // Default geometry of the instruction word
  localparam int DEF_DATA_W = 32;
  localparam int DEF_OPC_W  = 5;
  localparam int DEF_ADDR_W = 4;

  // LSB of register field k (0 = Ra, 1 = Rb, 2 = Rc), fields packed just below the opcode
  function automatic int field_lsb(input int data_w, input int opc_w, input int addr_w, input int k);
    return data_w - opc_w - (k + 1) * addr_w;
  endfunction

  // Next field to visit after cur, in order Ra, Rb, Rc; IDLE once no set field remains
  function automatic logic [1:0] next_step(input logic [1:0] cur, input logic [2:0] mask);
    logic [1:0] nxt;
    nxt = ST_IDLE;
    case (cur)
      ST_IDLE: begin
        if (mask[2])      nxt = ST_RA;
        else if (mask[1]) nxt = ST_RB;
        else if (mask[0]) nxt = ST_RC;
        else              nxt = ST_IDLE;
      end
      ST_RA: begin
        if (mask[1])      nxt = ST_RB;
        else if (mask[0]) nxt = ST_RC;
        else              nxt = ST_IDLE;
      end
      ST_RB: begin
        if (mask[0])      nxt = ST_RC;
        else              nxt = ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/select_encode_seq_onehot_decoder.sv
// Parametrised index-to-one-hot decoder with an out-of-range flag.
module se_onehot_decoder #(
  parameter int ADDR_W    = 4,
  parameter int REG_COUNT = 16
) (
  input  logic [ADDR_W-1:0]    idx_i,
  output logic [REG_COUNT-1:0] onehot_o,
  output logic                 oor_o
);

  // One bit per implemented register; indices past REG_COUNT leave the vector empty
  always_comb begin
    onehot_o = {REG_COUNT{1'b0}};
    for (int i = 0; i < REG_COUNT; i++) begin
      if (idx_i == ADDR_W'(i)) onehot_o[i] = 1'b1;
      else                     onehot_o[i] = 1'b0;
    end
    oor_o = ({1'b0, idx_i} >= (ADDR_W + 1)'(REG_COUNT));
  end

endmodule

// File: rtl/select_encode_seq.sv
// Registered register-file select/encode unit with direct and auto-sequence modes.
module select_encode_seq
  import select_encode_seq_pkg::*;
#(
  parameter int REG_COUNT = 16,
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 32,
  parameter int OPC_W     = 5,
  parameter int CONST_W   = 19
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic [DATA_W-1:0]    instruction,
  input  logic                 ir_load,
  input  logic                 Gra,
  input  logic                 Grb,
  input  logic                 Grc,
  input  logic                 r_enable,
  input  logic                 r_select,
  input  logic                 BAout,
  input  logic                 c_zext,
  input  logic                 seq_start,
  input  logic [2:0]           seq_mask,
  output logic [REG_COUNT-1:0] register_enable,
  output logic [REG_COUNT-1:0] register_select,
  output logic                 r0_zero,
  output logic [DATA_W-1:0]    C_ext_data,
  output logic [1:0]           field_id,
  output logic                 seq_busy,
  output logic                 seq_done,
  output logic                 index_err
);

  localparam int RA_LSB = field_lsb(DATA_W, OPC_W, ADDR_W, 0);
  localparam int RB_LSB = field_lsb(DATA_W, OPC_W, ADDR_W, 1);
  localparam int RC_LSB = field_lsb(DATA_W, OPC_W, ADDR_W, 2);

  logic [DATA_W-1:0]    ir_q, ir_d;
  logic [1:0]           state_q, state_d;
  logic [2:0]           mask_q, mask_d;
  logic [1:0]           fid_d;
  logic                 busy_d, done_d;
  logic [ADDR_W-1:0]    idx_s;
  logic [REG_COUNT-1:0] dec_onehot_s;
  logic                 dec_oor_s;
  logic                 field_act_s;
  logic [REG_COUNT-1:0] en_d, sel_d;
  logic                 r0_d, err_d;
  logic [CONST_W-1:0]   c_field_s;
  logic [DATA_W-1:0]    cext_d;
  logic                 unused_opc_s;

  // Opcode bits are latched with the word but not decoded here
  assign unused_opc_s = ^ir_d[DATA_W-1 -: OPC_W];

  // Field latch only follows the IR while idle so a sequence sees a stable snapshot
  always_comb begin
    if ((state_q == ST_IDLE) && ir_load) ir_d = instruction;
    else                                 ir_d = ir_q;
  end

  // Sequencer next state and active-field selection (direct mode only when idle and not sequencing)
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    fid_d   = FID_NONE;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    if (state_q == ST_IDLE) begin
      if (seq_start && (seq_mask != 3'b000)) begin
        state_d = next_step(ST_IDLE, seq_mask);
        mask_d  = seq_mask;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      state_d = next_step(state_q, mask_q);
    end
    if (state_d != ST_IDLE) begin
      // Step state codes equal the field_id codes of the field they emit
      fid_d  = state_d;
      busy_d = 1'b1;
      done_d = (next_step(state_d, mask_d) == ST_IDLE);
    end else if (state_q == ST_IDLE) begin
      if (Gra)      fid_d = FID_RA;
      else if (Grb) fid_d = FID_RB;
      else if (Grc) fid_d = FID_RC;
      else          fid_d = FID_NONE;
    end else begin
      fid_d = FID_NONE;
    end
  end

  // Pick the register index of the active field
  always_comb begin
    case (fid_d)
      FID_RA:  idx_s = ir_d[RA_LSB +: ADDR_W];
      FID_RB:  idx_s = ir_d[RB_LSB +: ADDR_W];
      FID_RC:  idx_s = ir_d[RC_LSB +: ADDR_W];
      default: idx_s = {ADDR_W{1'b0}};
    endcase
  end

  se_onehot_decoder #(
    .ADDR_W    (ADDR_W),
    .REG_COUNT (REG_COUNT)
  ) u_dec (
    .idx_i    (idx_s),
    .onehot_o (dec_onehot_s),
    .oor_o    (dec_oor_s)
  );

  // Qualify the decoded vector and form the extended constant
  always_comb begin
    field_act_s = (fid_d != FID_NONE);
    if (field_act_s && r_enable)             en_d = dec_onehot_s;
    else                                     en_d = {REG_COUNT{1'b0}};
    if (field_act_s && (r_select || BAout))  sel_d = dec_onehot_s;
    else                                     sel_d = {REG_COUNT{1'b0}};
    // R0 keeps its select bit so the bus mux can route the zero source
    r0_d  = BAout && field_act_s && (idx_s == {ADDR_W{1'b0}}) && sel_d[0];
    err_d = field_act_s && dec_oor_s;
    c_field_s = ir_d[CONST_W-1:0];
    if (c_zext) cext_d = {{(DATA_W-CONST_W){1'b0}}, c_field_s};
    else        cext_d = {{(DATA_W-CONST_W){c_field_s[CONST_W-1]}}, c_field_s};
  end

  // State, latch and output registers; clear forces everything to zero at once
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      ir_q            <= {DATA_W{1'b0}};
      state_q         <= ST_IDLE;
      mask_q          <= 3'b000;
      register_enable <= {REG_COUNT{1'b0}};
      register_select <= {REG_COUNT{1'b0}};
      r0_zero         <= 1'b0;
      C_ext_data      <= {DATA_W{1'b0}};
      field_id        <= FID_NONE;
      seq_busy        <= 1'b0;
      seq_done        <= 1'b0;
      index_err       <= 1'b0;
    end else begin
      ir_q            <= ir_d;
      state_q         <= state_d;
      mask_q          <= mask_d;
      register_enable <= en_d;
      register_select <= sel_d;
      r0_zero         <= r0_d;
      C_ext_data      <= cext_d;
      field_id        <= fid_d;
      seq_busy        <= busy_d;
      seq_done        <= done_d;
      index_err       <= err_d;
    end
  end

endmodule

// File: tb/tb_select_encode_seq.sv
// Scoreboard bench for select_encode_seq (16-register and 12-register builds).
module tb_select_encode_seq;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] instruction;
  logic        ir_load, Gra, Grb, Grc, r_enable, r_select, BAout, c_zext, seq_start;
  logic [2:0]  seq_mask;

  logic [15:0] en16, sel16;
  logic        r0_16, busy16, done16, err16;
  logic [31:0] cext16;
  logic [1:0]  fid16;

  logic [11:0] en12, sel12;
  logic        r0_12, busy12, done12, err12;
  logic [31:0] cext12;
  logic [1:0]  fid12;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    logic [15:0] en;
    logic [15:0] sel;
    logic        r0;
    logic [1:0]  fid;
    logic        busy;
    logic        done;
    logic        err;
  } exp_t;

  exp_t sb_q[$];

  always #5 clock = ~clock;

  select_encode_seq dut16 (
    .clock(clock), .clear(clear), .instruction(instruction), .ir_load(ir_load),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .r_enable(r_enable), .r_select(r_select),
    .BAout(BAout), .c_zext(c_zext), .seq_start(seq_start), .seq_mask(seq_mask),
    .register_enable(en16), .register_select(sel16), .r0_zero(r0_16),
    .C_ext_data(cext16), .field_id(fid16), .seq_busy(busy16), .seq_done(done16),
    .index_err(err16)
  );

  select_encode_seq #(.REG_COUNT(12)) dut12 (
    .clock(clock), .clear(clear), .instruction(instruction), .ir_load(ir_load),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .r_enable(r_enable), .r_select(r_select),
    .BAout(BAout), .c_zext(c_zext), .seq_start(seq_start), .seq_mask(seq_mask),
    .register_enable(en12), .register_select(sel12), .r0_zero(r0_12),
    .C_ext_data(cext12), .field_id(fid12), .seq_busy(busy12), .seq_done(done12),
    .index_err(err12)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string name, input logic [15:0] en, input logic [15:0] sel,
                          input logic r0, input logic [1:0] fid, input logic busy,
                          input logic done, input logic err);
    exp_t e;
    e.name = name; e.en = en; e.sel = sel; e.r0 = r0; e.fid = fid;
    e.busy = busy; e.done = done; e.err = err;
    sb_q.push_back(e);
  endtask

  // Advance one clock; compare the oldest pending expectation against dut16
  task automatic tick();
    exp_t e;
    @(posedge clock);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val({e.name, ".en"},   {16'h0, en16},   {16'h0, e.en});
      check_val({e.name, ".sel"},  {16'h0, sel16},  {16'h0, e.sel});
      check_val({e.name, ".r0"},   {31'h0, r0_16},  {31'h0, e.r0});
      check_val({e.name, ".fid"},  {30'h0, fid16},  {30'h0, e.fid});
      check_val({e.name, ".busy"}, {31'h0, busy16}, {31'h0, e.busy});
      check_val({e.name, ".done"}, {31'h0, done16}, {31'h0, e.done});
      check_val({e.name, ".err"},  {31'h0, err16},  {31'h0, e.err});
    end
  endtask

  task automatic idle_inputs();
    ir_load = 1'b0; Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
    r_enable = 1'b0; r_select = 1'b0; BAout = 1'b0; c_zext = 1'b0;
    seq_start = 1'b0; seq_mask = 3'b000;
  endtask

  task automatic load_ir(input logic [31:0] w);
    idle_inputs();
    instruction = w;
    ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b1;
    instruction = 32'h0;
    idle_inputs();
    #12;
    check_val("rst.en",   {16'h0, en16},   32'h0);
    check_val("rst.sel",  {16'h0, sel16},  32'h0);
    check_val("rst.cext", cext16,          32'h0);
    check_val("rst.busy", {31'h0, busy16}, 32'h0);
    @(negedge clock);
    clear = 1'b0;

    // Direct decode: Ra=5 Rb=3 Rc=0, Grb with r_select
    load_ir(32'h0A98_0000);
    Grb = 1'b1; r_select = 1'b1;
    push_exp("direct_rb", 16'h0000, 16'h0008, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0);
    tick();

    // Priority Gra over Grb with Ra=0 and BAout
    load_ir(32'h0818_0000);
    Gra = 1'b1; Grb = 1'b1; BAout = 1'b1;
    push_exp("prio_ba", 16'h0000, 16'h0001, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    tick();
    Gra = 1'b0;
    push_exp("ba_rb", 16'h0000, 16'h0008, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0);
    tick();
    idle_inputs(); Grc = 1'b1; r_enable = 1'b1;
    push_exp("direct_rc", 16'h0001, 16'h0000, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0);
    tick();
    Grc = 1'b0;
    push_exp("no_gr", 16'h0000, 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();

    // Full sequence Ra=1 Rb=2 Rc=4; ir_load and Gra during it must be ignored
    load_ir(32'h0092_0000);
    r_enable = 1'b1; seq_start = 1'b1; seq_mask = 3'b111;
    push_exp("seq7_ra", 16'h0002, 16'h0000, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0);
    tick();
    seq_start = 1'b0; instruction = 32'hFFFF_FFFF; ir_load = 1'b1; Gra = 1'b1;
    push_exp("seq7_rb", 16'h0004, 16'h0000, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0);
    tick();
    push_exp("seq7_rc", 16'h0010, 16'h0000, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0);
    tick();
    push_exp("seq7_end", 16'h0000, 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    ir_load = 1'b0;
    push_exp("seq7_latch", 16'h0002, 16'h0000, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
    tick();

    // Masked sequence Ra then Rc, then an empty mask
    Gra = 1'b0; seq_start = 1'b1; seq_mask = 3'b101;
    push_exp("seq5_ra", 16'h0002, 16'h0000, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0);
    tick();
    seq_start = 1'b0;
    push_exp("seq5_rc", 16'h0010, 16'h0000, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0);
    tick();
    push_exp("seq5_end", 16'h0000, 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    seq_start = 1'b1; seq_mask = 3'b000;
    push_exp("seq0_a", 16'h0000, 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    push_exp("seq0_b", 16'h0000, 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();

    // Constant extension and range: Ra=13, C=0x40000 (Rc=8)
    load_ir(32'h0684_0000);
    check_val("cext_sign", cext16, 32'hFFFC_0000);
    c_zext = 1'b1;
    tick();
    check_val("cext_zero", cext16, 32'h0004_0000);
    check_val("cext_zero12", cext12, 32'h0004_0000);
    Gra = 1'b1; r_enable = 1'b1; r_select = 1'b1;
    push_exp("range16", 16'h2000, 16'h2000, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
    tick();
    check_val("range12.en",  {20'h0, en12},  32'h0);
    check_val("range12.sel", {20'h0, sel12}, 32'h0);
    check_val("range12.err", {31'h0, err12}, 32'h1);
    Gra = 1'b0; Grc = 1'b1;
    push_exp("rc8_16", 16'h0100, 16'h0100, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0);
    tick();
    check_val("rc8_12.en",  {20'h0, en12},  32'h100);
    check_val("rc8_12.err", {31'h0, err12}, 32'h0);

    // Reset mid-sequence while in S_RB, then restart from Ra with a cleared latch
    load_ir(32'h0092_0000);
    r_enable = 1'b1; seq_start = 1'b1; seq_mask = 3'b111;
    push_exp("rst_seq_ra", 16'h0002, 16'h0000, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0);
    tick();
    seq_start = 1'b0;
    push_exp("rst_seq_rb", 16'h0004, 16'h0000, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0);
    tick();
    #2 clear = 1'b1;
    #1;
    check_val("midrst.en",   {16'h0, en16},   32'h0);
    check_val("midrst.fid",  {30'h0, fid16},  32'h0);
    check_val("midrst.busy", {31'h0, busy16}, 32'h0);
    check_val("midrst.cext", cext16,          32'h0);
    clear = 1'b0;
    seq_start = 1'b1; seq_mask = 3'b111;
    push_exp("restart_ra", 16'h0001, 16'h0000, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0);
    tick();
    seq_start = 1'b0;
    push_exp("restart_rb", 16'h0001, 16'h0000, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0);
    tick();
    push_exp("restart_rc", 16'h0001, 16'h0000, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0);
    tick();
    idle_inputs();
    tick();

    check_val("sb_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/select_encode_seq.md
Name: select_encode_seq

Overview:
Parametrised, registered select-and-encode unit for the datapath register file. It latches the instruction register fields and decodes Ra/Rb/Rc into one-hot register enable/select vectors. It forms constant C, sign- or zero-extended. Beyond single-field direct decode, it has an auto-sequence mode that steps through a masked set of fields on consecutive cycles, so the control unit can issue multi-register operand reads or writes from one start strobe.

Parameters:
REG_COUNT, 16, number of general registers; one-hot vector width.
ADDR_W, 4, register field width; must satisfy 2**ADDR_W >= REG_COUNT.
DATA_W, 32, instruction and constant output width.
OPC_W, 5, opcode field width at the instruction MSBs.
CONST_W, 19, width of constant C field at instruction LSBs.

Ports:
clock  in  1  system clock, rising edge.
clear  in  1  asynchronous active-high reset.
instruction  in  DATA_W  IR contents.
ir_load  in  1  capture instruction into internal field latch.
Gra, Grb, Grc  in  1 each  direct field select.
r_enable  in  1  qualify enable output.
r_select  in  1  qualify select output.
BAout  in  1  base-address read; R0 reads as zero.
c_zext  in  1  1 = zero-extend C, 0 = sign-extend.
seq_start  in  1  begin auto-sequence.
seq_mask  in  3  fields to visit: bit2 Ra, bit1 Rb, bit0 Rc.
register_enable  out  REG_COUNT  one-hot write enable.
register_select  out  REG_COUNT  one-hot read select.
r0_zero  out  1  R0 must drive zero onto the bus.
C_ext_data  out  DATA_W  extended constant C.
field_id  out  2  active field: 0 none, 1 Ra, 2 Rb, 3 Rc.
seq_busy  out  1  sequence in progress.
seq_done  out  1  one-cycle pulse on the final sequence step.
index_err  out  1  decoded index >= REG_COUNT.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. clear asserts all outputs to 0, the field latch to 0, and the FSM to IDLE, immediately and mid-sequence alike.
- Field latch: Ra = instruction[DATA_W-OPC_W-1 -: ADDR_W], Rb the next ADDR_W bits, Rc the next ADDR_W bits. With defaults: Ra [26:23], Rb [22:19], Rc [18:15].
  - The latch loads on ir_load while IDLE.
  - ir_load while busy is ignored; the sequence works from a stable snapshot.
- Constant: C_ext_data registers from the latch. It is sign-extended from bit CONST_W-1, or zero-extended when c_zext=1.
- Direct mode (IDLE, seq_start=0): field priority Gra > Grb > Grc. Multiple asserts never OR indices together. With no Gr asserted, field_id=0 and both vectors are 0.
- Output latency: outputs are registered, one cycle after the inputs are sampled.
- Vector forming:
  - register_enable = onehot(idx) when r_enable is 1.
  - register_select = onehot(idx) when r_select or BAout is 1.
  - r0_zero = BAout & (idx==0) & register_select asserted. R0's select bit stays set so the mux can pick the zero source.
- Out of range: idx >= REG_COUNT gives both vectors 0 and index_err=1 for that cycle.
- FSM states: IDLE, S_RA, S_RB, S_RC.
  - seq_start in IDLE with seq_mask != 0 goes to the first set field in order Ra, Rb, Rc.
  - Each state holds one cycle, emits that field, and moves to the next set field, or to IDLE after the last.
  - seq_busy=1 in all non-IDLE states.
  - seq_done pulses in the last visited state.
  - seq_start with seq_mask=0 is ignored; no state change, no done.
  - seq_start while busy is ignored.
  - Gr inputs are ignored while busy; r_enable, r_select and BAout still qualify each step.
- Sequence latency: a start at cycle t outputs the first field at t+1. A full mask completes in three cycles, with seq_done at t+3.

Decomposition:
- Shared package: field_id encodings (FID_NONE/RA/RB/RC), FSM state encoding, and field-offset localparams derived from DATA_W/OPC_W/ADDR_W.
- One sub-module: se_onehot_decoder, parametrised ADDR_W to REG_COUNT, with out-of-range flag. It replaces the fixed 4-to-16 decoder.

Test Plan:
1. Reset mid-sequence: assert clear in S_RB -> all outputs 0 at once; FSM IDLE; the next seq_start restarts from Ra.
2. Direct decode: ir_load 0x0A980000 (Ra=5, Rb=3, Rc=0), Grb=1, r_select=1 -> next cycle register_select=0x0008, field_id=2, register_enable=0.
3. Priority and BAout: same IR with Ra=0, Gra=Grb=1, BAout=1 -> register_select=0x0001, r0_zero=1; no OR of indices.
4. Full sequence: Ra=1, Rb=2, Rc=4, seq_mask=3'b111, r_enable=1 -> register_enable 0x0002, 0x0004, 0x0010 on t+1..t+3; seq_done only at t+3; ir_load during the sequence is ignored.
5. Masked sequence: seq_mask=3'b101 -> two steps, Ra then Rc; seq_mask=0 -> no busy, no done.
6. Constant and range: C field 0x40000 -> C_ext_data 0xFFFC0000 signed, 0x00040000 with c_zext=1. REG_COUNT=12, idx=13 -> vectors 0, index_err=1.
